kernel_bank_scheduler: RTL and testbench

Sequences double-buffered kernel loading for a conv/FC layer. Weight RAM bank 0 is at WEIGHT_RAM_START_INDEX_0 and bias address 0; bank 1 is at WEIGHT_RAM_START_INDEX_1 and bias address 1. The block issues one-kernel fill requests to the file/DDR loader and grants filled banks to the compute engine. It keeps loading of kernel k+1 overlapped with computation on kernel k. It replaces ad-hoc update_kernel/update_kernel_number sequencing.

---
 rtl/kernel_bank_scheduler_if.sv | 29 ++
 rtl/kernel_bank_scheduler.sv | 138 +++++++++++++
 tb/tb_kernel_bank_scheduler.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/kernel_bank_scheduler_if.sv
// Handshake bundle between the kernel bank scheduler, the weight loader and the compute engine.
// The master side is the scheduler; the slave side is the loader/compute environment.
interface kernel_bank_scheduler_if #(
  parameter int IDX_W = 9
);
  logic             start;
  logic [IDX_W-1:0] kernel_total;
  logic             load_req;
  logic             load_bank;
  logic [IDX_W-1:0] load_idx;
  logic             load_done;
  logic             comp_req;
  logic             comp_grant;
  logic             comp_bank;
  logic [IDX_W-1:0] comp_idx;
  logic             comp_release;
  logic             layer_done;
  logic             busy;

  modport master (
    input  start, kernel_total, load_done, comp_req, comp_release,
    output load_req, load_bank, load_idx, comp_grant, comp_bank, comp_idx, layer_done, busy
  );

  modport slave (
    output start, kernel_total, load_done, comp_req, comp_release,
    input  load_req, load_bank, load_idx, comp_grant, comp_bank, comp_idx, layer_done, busy
  );
endinterface

// File: rtl/kernel_bank_scheduler.sv
// Double-buffered kernel scheduler: ping-pongs weight banks between the loader and compute,
// keeping the load of kernel k+1 overlapped with compute on kernel k.
module kernel_bank_scheduler #(
  parameter int IDX_W         = 9,
  parameter int DEFAULT_TOTAL = 96
) (
  input  logic                   clk,
  input  logic                   rst,
  kernel_bank_scheduler_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [1:0] {EMPTY, LOADING, FULL, INUSE} bank_e;

  state_e           state_q, state_d;
  bank_e            bank_q [2];
  bank_e            bank_d [2];
  logic [IDX_W-1:0] total_q, total_d;
  logic [IDX_W-1:0] next_load_q, next_load_d;
  logic [IDX_W-1:0] next_comp_q, next_comp_d;
  logic             load_req_q, load_req_d;
  logic             load_bank_q, load_bank_d;
  logic [IDX_W-1:0] load_idx_q, load_idx_d;
  logic             comp_grant_q, comp_grant_d;
  logic             comp_bank_q, comp_bank_d;
  logic [IDX_W-1:0] comp_idx_q, comp_idx_d;
  logic             layer_done_q, layer_done_d;

  logic [IDX_W-1:0] start_total;
  logic             inuse_any;

  assign start_total = (&bus.kernel_total) ? IDX_W'(DEFAULT_TOTAL) : bus.kernel_total;
  assign inuse_any   = (bank_q[0] == INUSE) || (bank_q[1] == INUSE);

  always_comb begin
    state_d      = state_q;
    bank_d       = bank_q;
    total_d      = total_q;
    next_load_d  = next_load_q;
    next_comp_d  = next_comp_q;
    load_req_d   = load_req_q;
    load_bank_d  = load_bank_q;
    load_idx_d   = load_idx_q;
    comp_grant_d = 1'b0;
    comp_bank_d  = comp_bank_q;
    comp_idx_d   = comp_idx_q;
    layer_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          total_d     = start_total;
          next_load_d = '0;
          next_comp_d = '0;
          bank_d[0]   = EMPTY;
          bank_d[1]   = EMPTY;
          if (start_total == '0) begin
            state_d      = DONE;
            layer_done_d = 1'b1;
          end else begin
            // Kernel 0 is issued on the start edge so load_req is up in the first RUN cycle.
            state_d     = RUN;
            load_req_d  = 1'b1;
            load_bank_d = 1'b0;
            load_idx_d  = '0;
            bank_d[0]   = LOADING;
          end
        end
      end
      RUN: begin
        if (load_req_q && bus.load_done) begin
          load_req_d          = 1'b0;
          bank_d[load_bank_q] = FULL;
          next_load_d         = next_load_q + 1'b1;
        end else if (!load_req_q && (next_load_q < total_q) && (bank_q[next_load_q[0]] == EMPTY)) begin
          load_req_d              = 1'b1;
          load_bank_d             = next_load_q[0];
          load_idx_d              = next_load_q;
          bank_d[next_load_q[0]]  = LOADING;
        end
        // A release and a grant never share an edge: the released bank is still INUSE this cycle.
        if (bus.comp_release && inuse_any) begin
          bank_d[comp_bank_q] = EMPTY;
          next_comp_d         = next_comp_q + 1'b1;
          if (next_comp_d == total_q) begin
            state_d      = DONE;
            layer_done_d = 1'b1;
          end
        end else if (bus.comp_req && !inuse_any && (bank_q[next_comp_q[0]] == FULL)) begin
          comp_grant_d           = 1'b1;
          comp_bank_d            = next_comp_q[0];
          comp_idx_d             = next_comp_q;
          bank_d[next_comp_q[0]] = INUSE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bank_q[0]    <= EMPTY;
      bank_q[1]    <= EMPTY;
      total_q      <= '0;
      next_load_q  <= '0;
      next_comp_q  <= '0;
      load_req_q   <= 1'b0;
      load_bank_q  <= 1'b0;
      load_idx_q   <= '0;
      comp_grant_q <= 1'b0;
      comp_bank_q  <= 1'b0;
      comp_idx_q   <= '0;
      layer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      total_q      <= total_d;
      next_load_q  <= next_load_d;
      next_comp_q  <= next_comp_d;
      load_req_q   <= load_req_d;
      load_bank_q  <= load_bank_d;
      load_idx_q   <= load_idx_d;
      comp_grant_q <= comp_grant_d;
      comp_bank_q  <= comp_bank_d;
      comp_idx_q   <= comp_idx_d;
      layer_done_q <= layer_done_d;
    end
  end

  assign bus.load_req   = load_req_q;
  assign bus.load_bank  = load_bank_q;
  assign bus.load_idx   = load_idx_q;
  assign bus.comp_grant = comp_grant_q;
  assign bus.comp_bank  = comp_bank_q;
  assign bus.comp_idx   = comp_idx_q;
  assign bus.layer_done = layer_done_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_kernel_bank_scheduler.sv
// Bench for kernel_bank_scheduler: table-driven whole layers against a load/grant scoreboard,
// then hand-written cycle-exact sequences for overlap, backpressure, reset and spurious inputs.
module tb_kernel_bank_scheduler;
  localparam int IDX_W = 9;

  typedef struct {
    logic [IDX_W-1:0] total;
    int               exp_n;
    int               l_lat;
    int               c_lat;
  } vec_t;

  typedef struct {
    logic             bank;
    logic [IDX_W-1:0] idx;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kernel_bank_scheduler_if #(.IDX_W(IDX_W)) bus ();

  kernel_bank_scheduler #(.IDX_W(IDX_W), .DEFAULT_TOTAL(96)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int   checks = 0;
  int   errors = 0;
  bit   auto_en = 0;
  bit   sb_en = 0;
  bit   prev_lr = 0;
  int   done_cnt = 0;
  int   l_lat, c_lat, l_cnt, c_cnt;
  bit   c_busy;
  ev_t  load_q[$];
  ev_t  grant_q[$];
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    ev_t e;
    if (bus.layer_done) done_cnt++;
    if (sb_en && bus.load_req && !prev_lr) begin
      checks++;
      if (load_q.size() == 0) begin
        errors++;
        $display("FAIL load_extra: got idx %0h, expected no load", bus.load_idx);
      end else begin
        e = load_q.pop_front();
        chk("load_bank", 32'(bus.load_bank), 32'(e.bank));
        chk("load_idx", 32'(bus.load_idx), 32'(e.idx));
      end
    end
    if (sb_en && bus.comp_grant) begin
      checks++;
      if (grant_q.size() == 0) begin
        errors++;
        $display("FAIL grant_extra: got idx %0h, expected no grant", bus.comp_idx);
      end else begin
        e = grant_q.pop_front();
        chk("grant_bank", 32'(bus.comp_bank), 32'(e.bank));
        chk("grant_idx", 32'(bus.comp_idx), 32'(e.idx));
      end
    end
    prev_lr = bus.load_req;
  endtask

  // One cycle: sample at negedge, then let the auto loader/compute agents respond.
  task automatic tick();
    @(negedge clk);
    monitor();
    if (auto_en) begin
      if (bus.load_done) bus.load_done = 1'b0;
      else if (bus.load_req) begin
        if (l_cnt >= l_lat) begin bus.load_done = 1'b1; l_cnt = 0; end
        else l_cnt++;
      end
      if (bus.comp_release) bus.comp_release = 1'b0;
      else begin
        if (bus.comp_grant) begin c_busy = 1'b1; c_cnt = 0; end
        if (c_busy) begin
          if (c_cnt >= c_lat) begin bus.comp_release = 1'b1; c_busy = 1'b0; end
          else c_cnt++;
        end
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_load_req"}, 32'(bus.load_req), 0);
    chk({tag, "_load_bank"}, 32'(bus.load_bank), 0);
    chk({tag, "_load_idx"}, 32'(bus.load_idx), 0);
    chk({tag, "_comp_grant"}, 32'(bus.comp_grant), 0);
    chk({tag, "_comp_bank"}, 32'(bus.comp_bank), 0);
    chk({tag, "_comp_idx"}, 32'(bus.comp_idx), 0);
    chk({tag, "_layer_done"}, 32'(bus.layer_done), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  task automatic clear_inputs();
    bus.start = 0; bus.kernel_total = '0; bus.load_done = 0;
    bus.comp_req = 0; bus.comp_release = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic pulse_start(input logic [IDX_W-1:0] tot);
    bus.start = 1'b1; bus.kernel_total = tot; tick(); bus.start = 1'b0;
  endtask

  initial begin
    ev_t e;
    vecs[0] = '{9'd3,   3,  0, 0};
    vecs[1] = '{9'd1,   1,  2, 1};
    vecs[2] = '{9'd5,   5,  1, 3};
    vecs[3] = '{9'd4,   4,  3, 0};
    vecs[4] = '{9'd0,   0,  0, 0};
    vecs[5] = '{9'h1FF, 96, 0, 1};
    vecs[6] = '{9'd2,   2,  4, 4};
    vecs[7] = '{9'd7,   7,  0, 5};

    clear_inputs();
    do_reset();
    chk_all_zero("reset");

    foreach (vecs[v]) begin
      do_reset();
      clear_inputs();
      load_q.delete(); grant_q.delete();
      for (int k = 0; k < vecs[v].exp_n; k++) begin
        e.bank = k[0];
        e.idx  = IDX_W'(k);
        load_q.push_back(e);
        grant_q.push_back(e);
      end
      l_lat = vecs[v].l_lat; c_lat = vecs[v].c_lat;
      l_cnt = 0; c_cnt = 0; c_busy = 0;
      auto_en = 1; sb_en = 1; bus.comp_req = 1'b1; done_cnt = 0;
      pulse_start(vecs[v].total);
      for (int n = 0; n < 4000 && done_cnt == 0; n++) tick();
      checks++;
      if (done_cnt == 0) begin
        errors++;
        $display("FAIL vec%0d_timeout: got no layer_done, expected one within 4000 cycles", v);
      end
      tick();
      chk($sformatf("vec%0d_busy_after", v), 32'(bus.busy), 0);
      chk($sformatf("vec%0d_done_low", v), 32'(bus.layer_done), 0);
      tick(); tick();
      chk($sformatf("vec%0d_done_pulses", v), 32'(done_cnt), 1);
      chk($sformatf("vec%0d_loads_left", v), 32'(load_q.size()), 0);
      chk($sformatf("vec%0d_grants_left", v), 32'(grant_q.size()), 0);
      auto_en = 0; sb_en = 0;
      clear_inputs();
    end

    // total=0: single DONE cycle, no load
    do_reset(); clear_inputs();
    pulse_start(9'd0);
    chk("z_layer_done", 32'(bus.layer_done), 1);
    chk("z_busy", 32'(bus.busy), 1);
    chk("z_load_req", 32'(bus.load_req), 0);
    tick();
    chk("z_busy_after", 32'(bus.busy), 0);
    chk("z_done_after", 32'(bus.layer_done), 0);

    // total=4, compute idle: two loads then backpressure; spurious inputs ignored
    do_reset(); clear_inputs();
    pulse_start(9'd4);
    chk("bp_lr0", 32'(bus.load_req), 1);
    chk("bp_lb0", 32'(bus.load_bank), 0);
    chk("bp_li0", 32'(bus.load_idx), 0);
    bus.load_done = 1; tick(); bus.load_done = 0;
    chk("bp_lr0_drop", 32'(bus.load_req), 0);
    tick();
    chk("bp_lr1", 32'(bus.load_req), 1);
    chk("bp_lb1", 32'(bus.load_bank), 1);
    chk("bp_li1", 32'(bus.load_idx), 1);
    bus.load_done = 1; tick(); bus.load_done = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("bp_stall_lr", 32'(bus.load_req), 0);
    end
    bus.comp_release = 1; bus.load_done = 1; bus.start = 1; bus.kernel_total = 9'd0;
    tick();
    clear_inputs();
    chk("sp_layer_done", 32'(bus.layer_done), 0);
    chk("sp_busy", 32'(bus.busy), 1);
    chk("sp_grant", 32'(bus.comp_grant), 0);
    tick();
    chk("sp_lr", 32'(bus.load_req), 0);
    bus.comp_req = 1; tick();
    chk("bp_grant", 32'(bus.comp_grant), 1);
    chk("bp_gbank", 32'(bus.comp_bank), 0);
    chk("bp_gidx", 32'(bus.comp_idx), 0);
    tick();
    chk("bp_grant_once", 32'(bus.comp_grant), 0);
    bus.comp_release = 1; tick(); bus.comp_release = 0;
    chk("bp_rel_lr", 32'(bus.load_req), 0);
    tick();
    chk("bp_reload_lr", 32'(bus.load_req), 1);
    chk("bp_reload_lb", 32'(bus.load_bank), 0);
    chk("bp_reload_li", 32'(bus.load_idx), 2);
    chk("bp_regrant_b1", 32'(bus.comp_grant), 1);
    chk("bp_regrant_idx", 32'(bus.comp_idx), 1);

    // total=4, load_done(idx1) and comp_release(idx0) on the same edge
    do_reset(); clear_inputs();
    bus.comp_req = 1;
    pulse_start(9'd4);
    bus.load_done = 1; tick(); bus.load_done = 0;
    chk("ov_lr_drop", 32'(bus.load_req), 0);
    chk("ov_no_early_grant", 32'(bus.comp_grant), 0);
    tick();
    chk("ov_lr1", 32'(bus.load_req), 1);
    chk("ov_lb1", 32'(bus.load_bank), 1);
    chk("ov_li1", 32'(bus.load_idx), 1);
    chk("ov_grant0", 32'(bus.comp_grant), 1);
    chk("ov_gbank0", 32'(bus.comp_bank), 0);
    bus.load_done = 1; bus.comp_release = 1; tick();
    bus.load_done = 0; bus.comp_release = 0;
    chk("ov_both_lr", 32'(bus.load_req), 0);
    chk("ov_both_grant", 32'(bus.comp_grant), 0);
    tick();
    chk("ov_lr2", 32'(bus.load_req), 1);
    chk("ov_lb2", 32'(bus.load_bank), 0);
    chk("ov_li2", 32'(bus.load_idx), 2);
    chk("ov_grant1", 32'(bus.comp_grant), 1);
    chk("ov_gbank1", 32'(bus.comp_bank), 1);
    chk("ov_gidx1", 32'(bus.comp_idx), 1);

    // reset with a load outstanding, then restart from kernel 0
    rst = 1; tick(); rst = 0;
    chk_all_zero("midrst");
    bus.comp_req = 0;
    tick();
    pulse_start(9'd2);
    chk("rs_lr", 32'(bus.load_req), 1);
    chk("rs_lb", 32'(bus.load_bank), 0);
    chk("rs_li", 32'(bus.load_idx), 0);
    chk("rs_busy", 32'(bus.busy), 1);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
